// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between an instruction-fetch requester and a
// load/store requester. Data accesses win by default. A starvation counter
// hands the port to a waiting fetch after STARVE_MAX consecutive data grants.
// Every transaction walks IDLE -> GNT_x -> RESP -> IDLE, so the peak rate is
// one transaction every three cycles.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   i_req/i_addr      fetch request, held until i_ack
//   i_ack/i_rdata     one-cycle fetch completion pulse and fetched word
//   d_req/d_addr/d_we/d_wdata/d_mode   load/store request, held until d_ack
//   d_ack/d_rdata     one-cycle load/store completion pulse and load data
//   m_req/m_addr/m_wdata/m_we/m_mode   shared memory command (registered)
//   m_rdata/m_ready   memory read data and completion strobe
//   busy              high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_mode,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic [2:0]        m_mode,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  starve_q,  starve_d;
  logic              m_req_q,   m_req_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_we_q,    m_we_d;
  logic [2:0]        m_mode_q,  m_mode_d;
  logic              i_ack_q,   i_ack_d;
  logic              d_ack_q,   d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q,    busy_d;
  logic              starved;

  // A waiting fetch that has already lost STARVE_MAX times in a row wins.
  assign starved = i_req && (starve_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = m_we_q;
    m_mode_d  = m_mode_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        // The winner's command is latched here, so requester inputs are
        // free to change for the rest of the transaction.
        if (d_req && !starved) begin
          state_d   = GNT_D;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_we_d    = d_we;
          m_mode_d  = d_mode;
          busy_d    = 1'b1;
          starve_d  = i_req ? sat_inc(starve_q) : '0;
        end else if (i_req) begin
          state_d   = GNT_I;
          m_req_d   = 1'b1;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_we_d    = 1'b0;
          m_mode_d  = MODE_WORD;
          busy_d    = 1'b1;
          starve_d  = '0;
        end
      end
      GNT_I: begin
        if (m_ready) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          i_rdata_d = m_rdata;
          i_ack_d   = 1'b1;
        end
      end
      GNT_D: begin
        // Stores capture m_rdata as well; the value is meaningless to them.
        if (m_ready) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          d_rdata_d = m_rdata;
          d_ack_d   = 1'b1;
        end
      end
      RESP: begin
        // Requests are not looked at here, giving a requester one cycle
        // after its ack to drop req without being granted again.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_we_q    <= 1'b0;
      m_mode_q  <= 3'b000;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
      m_mode_q  <= m_mode_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_we    = m_we_q;
  assign m_mode  = m_mode_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;

endmodule
